instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles spent waiting for imem_ready before fetch_err.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 Port PCSrc  input  1  SHALL be the branch-taken select from the control unit.
REQ-006 Port ImmExt  input  32  SHALL be the sign-extended branch offset from the immediate extender.
REQ-007 Port stall  input  1  SHALL make the consumer hold the current instruction while high.
REQ-008 Port imem_req  output  1  SHALL request a read from instruction memory.
REQ-009 Port imem_addr  output  32  SHALL carry the read address; it equals PC.
REQ-010 Port imem_ready  input  1  SHALL indicate that imem_rdata is valid this cycle.
REQ-011 Port imem_rdata  input  32  SHALL carry the instruction word read from memory.
REQ-012 Port Instr  output  32  SHALL carry the registered instruction; Instr[6:0] drives the decoder op.
REQ-013 Port PC  output  32  SHALL carry the address of Instr.
REQ-014 Port PCPlus4  output  32  SHALL equal PC + 4, modulo 2^32, combinationally.
REQ-015 Port instr_valid  output  1  SHALL mark Instr/PC as valid for decode.
REQ-016 Port fetch_err  output  1  SHALL be a sticky flag for an instruction-memory timeout.

Function
REQ-017 The FSM SHALL have three states: FETCH, HOLD and ERR.
REQ-018 In FETCH, imem_req SHALL be 1 and instr_valid SHALL be 0.
REQ-019 In FETCH with imem_ready=1, the block SHALL register Instr<=imem_rdata and move to HOLD at the next edge.
- Minimum fetch latency: 1 cycle from imem_req to instr_valid.
REQ-020 In HOLD, instr_valid SHALL be 1 and imem_req SHALL be 0.
REQ-021 In HOLD with stall=1, the block SHALL hold Instr and PC unchanged.
REQ-022 In HOLD with stall=0, the block SHALL update PC and return to FETCH at the next edge.
- PCSrc=1: PC <= PC + ImmExt.
- PCSrc=0: PC <= PC + 4.
REQ-023 PCSrc and ImmExt SHALL be sampled only in HOLD with stall=0 and ignored otherwise.
REQ-024 All PC arithmetic SHALL be 32-bit unsigned, wrapping modulo 2^32 (PC=32'hFFFF_FFFC, +4 -> 32'h0).
REQ-025 Bits [1:0] of the next PC SHALL be forced to 0, so a misaligned branch target is truncated to word alignment.
REQ-026 A wait counter SHALL clear on every entry to FETCH and increment each FETCH cycle with imem_ready=0.
REQ-027 When the wait counter reaches TIMEOUT, the block SHALL move to ERR.
REQ-028 In ERR, the block SHALL hold fetch_err=1, imem_req=0 and instr_valid=0 until reset.
REQ-029 If imem_ready and the timeout condition occur in the same cycle, imem_ready SHALL win (go to HOLD).
REQ-030 In FETCH, imem_addr SHALL remain stable until imem_ready is seen.
REQ-031 imem_ready SHALL be ignored outside FETCH.

Reset
REQ-032 Asserting reset, including mid-fetch, SHALL immediately force the following, without waiting for clk:
- PC=RESET_PC, Instr=32'h0000_0013 (NOP), state=FETCH, wait counter=0.
- instr_valid=0, fetch_err=0.
REQ-033 After reset deasserts, the first imem_req SHALL appear in the same cycle at address RESET_PC.

Verification
REQ-034 Sequential fetch, imem_ready=1 on every request and stall=0 -> PC sequence 0, 4, 8, 12; instr_valid toggles 1,0,1,0.
REQ-035 Taken branch, PC=32'h10 with ImmExt=32'hFFFF_FFF8 and PCSrc=1 in HOLD -> next imem_addr=32'h08; repeat with PCSrc=0 -> 32'h14.
REQ-036 Stall, stall=1 for 3 cycles in HOLD while PCSrc toggles -> Instr and PC constant, instr_valid=1, no imem_req; advance happens on the first cycle with stall=0.
REQ-037 Wait states, imem_ready delayed 5 cycles -> imem_addr stable throughout and Instr captures imem_rdata on the ready cycle.
- Timeout case: imem_ready never asserted -> fetch_err=1 after 15 wait cycles and remains set.
REQ-038 Async reset, reset pulsed between clock edges while in HOLD at PC=32'h40 -> PC=RESET_PC and instr_valid=0 before the next edge; fetch restarts at RESET_PC.
REQ-039 Wrap and misalignment, PC=32'hFFFF_FFFC sequential -> next PC 32'h0; ImmExt=32'h6 taken from PC=0 -> next PC 32'h4.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the instruction-memory request, captures the
// returned word, and holds it for decode until the consumer releases it. The
// next PC is either sequential (PC+4) or a branch target (PC+ImmExt), and it is
// always forced to word alignment. A memory that never answers within TIMEOUT
// wait cycles parks the block in a sticky error state.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] ImmExt,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        fetch_err
);

  localparam int          CW        = $clog2(TIMEOUT + 1);
  // Value the counter holds on the last tolerated wait cycle.
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } state_t;

  state_t        state_r;
  logic [CW-1:0] wait_r;
  logic [31:0]   pc_r;
  logic [31:0]   instr_r;
  logic          req_r;
  logic          valid_r;
  logic          err_r;

  logic [31:0]   pc_sum_s;
  logic [31:0]   pc_next_s;

  // Next-PC selection: branch target or sequential, truncated to a word boundary.
  always_comb begin
    pc_sum_s  = 32'h0000_0000;
    pc_next_s = 32'h0000_0000;
    if (PCSrc) begin
      pc_sum_s = pc_r + ImmExt;
    end else begin
      pc_sum_s = pc_r + 32'd4;
    end
    pc_next_s = pc_sum_s & 32'hFFFF_FFFC;
  end

  // Fetch FSM with registered request/valid/error outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
      wait_r  <= '0;
      pc_r    <= RESET_PC;
      instr_r <= NOP_INSTR;
      req_r   <= 1'b1;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          // A ready response wins over a simultaneous timeout.
          if (imem_ready) begin
            instr_r <= imem_rdata;
            state_r <= HOLD;
            req_r   <= 1'b0;
            valid_r <= 1'b1;
          end else if (wait_r == LAST_WAIT) begin
            state_r <= ERR;
            req_r   <= 1'b0;
            err_r   <= 1'b1;
          end else begin
            wait_r  <= wait_r + CW'(1);
          end
        end
        HOLD: begin
          if (!stall) begin
            pc_r    <= pc_next_s;
            wait_r  <= '0;
            state_r <= FETCH;
            req_r   <= 1'b1;
            valid_r <= 1'b0;
          end else begin
            state_r <= HOLD;
          end
        end
        ERR: begin
          state_r <= ERR;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
          err_r   <= 1'b1;
        end
        default: begin
          // An unreachable encoding is treated as a fault and parked in ERR.
          state_r <= ERR;
          req_r   <= 1'b0;
          valid_r <= 1'b0;
          err_r   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign PC          = pc_r;
  assign PCPlus4     = pc_r + 32'd4;
  assign Instr       = instr_r;
  assign instr_valid = valid_r;
  assign fetch_err   = err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int          TMO = 15;

  logic        clk;
  logic        reset;
  logic        PCSrc;
  logic [31:0] ImmExt;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] Instr;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        instr_valid;
  logic        fetch_err;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: "holding an instruction", "errored", wait count, PC, word.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  bit          m_holding;
  bit          m_err;
  int          m_wait;

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrc      (PCSrc),
    .ImmExt     (ImmExt),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .Instr      (Instr),
    .PC         (PC),
    .PCPlus4    (PCPlus4),
    .instr_valid(instr_valid),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = 32'h0000_0000;
    m_instr   = NOP;
    m_holding = 1'b0;
    m_err     = 1'b0;
    m_wait    = 0;
  endtask

  task automatic model_step(input logic rdy, input logic [31:0] rd, input logic st,
                            input logic ps, input logic [31:0] imm);
    logic [31:0] tgt;
    if (m_err) begin
      // stays errored until reset
    end else if (!m_holding) begin
      if (rdy) begin
        m_instr   = rd;
        m_holding = 1'b1;
      end else begin
        m_wait = m_wait + 1;
        if (m_wait >= TMO) m_err = 1'b1;
      end
    end else if (!st) begin
      tgt       = ps ? (m_pc + imm) : (m_pc + 32'd4);
      m_pc      = {tgt[31:2], 2'b00};
      m_holding = 1'b0;
      m_wait    = 0;
    end
  endtask

  task automatic check_all();
    chk("imem_req",    {31'd0, imem_req},    {31'd0, !m_holding && !m_err});
    chk("imem_addr",   imem_addr,            m_pc);
    chk("pc",          PC,                   m_pc);
    chk("pcplus4",     PCPlus4,              m_pc + 32'd4);
    chk("instr",       Instr,                m_instr);
    chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_holding && !m_err});
    chk("fetch_err",   {31'd0, fetch_err},   {31'd0, m_err});
  endtask

  task automatic cycle(input logic rdy, input logic [31:0] rd, input logic st,
                       input logic ps, input logic [31:0] imm);
    imem_ready = rdy;
    imem_rdata = rd;
    stall      = st;
    PCSrc      = ps;
    ImmExt     = imm;
    @(posedge clk);
    model_step(rdy, rd, st, ps, imm);
    #1;
    check_all();
  endtask

  task automatic do_fetch();
    cycle(1'b1, $urandom, 1'($urandom), 1'($urandom), $urandom);
  endtask

  task automatic do_adv(input logic ps, input logic [31:0] imm);
    cycle(1'($urandom), $urandom, 1'b0, ps, imm);
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    reset = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    reset = 1'b1; PCSrc = 1'b0; ImmExt = 32'h0; stall = 1'b0;
    imem_ready = 1'b0; imem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;
    #1;
    check_all();

    // Sequential fetch: 0,4,8,12 then on to 0x10.
    for (int i = 0; i < 4; i++) begin
      do_fetch();
      do_adv(1'b0, $urandom);
    end
    chk("seq_pc", imem_addr, 32'h0000_0010);

    // Taken branch backwards from 0x10, then sequential from 0x10.
    do_fetch();
    do_adv(1'b1, 32'hFFFF_FFF8);
    chk("branch_back", imem_addr, 32'h0000_0008);
    do_fetch();
    do_adv(1'b1, 32'h0000_0008);
    do_fetch();
    do_adv(1'b0, 32'h0000_0008);
    chk("branch_not_taken", imem_addr, 32'h0000_0014);

    // Stall for 3 cycles with PCSrc toggling.
    do_fetch();
    for (int i = 0; i < 3; i++) cycle(1'b1, $urandom, 1'b1, 1'(i), $urandom);
    do_adv(1'b0, 32'h0);
    chk("stall_adv", imem_addr, 32'h0000_0018);

    // Five wait states, then ready.
    for (int i = 0; i < 5; i++) cycle(1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom);
    cycle(1'b1, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
    chk("wait_capture", Instr, 32'hCAFE_F00D);

    // Async reset in HOLD at 0x40.
    do_adv(1'b1, 32'h0000_0040 - m_pc);
    do_fetch();
    chk("hold_at_40", PC, 32'h0000_0040);
    pulse_reset();
    do_fetch();
    do_adv(1'b0, 32'h0);

    // Wrap from 0xFFFF_FFFC and misaligned branch from 0.
    do_fetch();
    do_adv(1'b1, 32'hFFFF_FFFC - m_pc);
    do_fetch();
    do_adv(1'b0, 32'h0);
    chk("wrap", imem_addr, 32'h0000_0000);
    do_fetch();
    do_adv(1'b1, 32'h0000_0006);
    chk("misaligned", imem_addr, 32'h0000_0004);

    // Ready arriving on the last tolerated wait cycle wins over timeout.
    for (int i = 0; i < TMO - 1; i++) cycle(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    chk("ready_wins", {31'd0, instr_valid}, 32'd1);
    do_adv(1'b0, 32'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(9, 0) < 7), $urandom, ($urandom_range(3, 0) == 0),
            1'($urandom), $urandom);
    end
    if (m_err) pulse_reset();
    if (m_holding) do_adv(1'b0, 32'h0);

    // Timeout: memory never answers.
    for (int i = 0; i < TMO + 5; i++) cycle(1'b0, $urandom, 1'($urandom), 1'($urandom), $urandom);
    chk("timeout_sticky", {31'd0, fetch_err}, 32'd1);
    cycle(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    chk("err_ignores_ready", {31'd0, instr_valid}, 32'd0);
    pulse_reset();
    do_fetch();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
